// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory
//               arbiter (response-owner encoding, address-range check).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

   // Default word-address width of the shared instruction memory (1024 words)
   localparam int IMEM_ADDR_W = 10;

   // Byte-offset bits that must be zero for a legal word access
   localparam logic [31:0] IMEM_ALIGN_MASK = 32'h0000_0003;

   // Who owns the read data returned by the memory in the current cycle
   typedef enum logic [1:0] {
      RSP_NONE  = 2'd0,
      RSP_IF    = 2'd1,
      RSP_LD_RD = 2'd2,
      RSP_ERR   = 2'd3
   } rsp_owner_e;

   // A loader address is legal when word-aligned and inside the memory
   function automatic logic ld_addr_ok(input logic [31:0] addr, input int addr_w);
      logic [31:0] upper;
      upper = addr >> (addr_w + 2);
      return ((addr & IMEM_ALIGN_MASK) == 32'd0) && (upper == 32'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : imem_starve_cnt
// Description : Counts consecutive loader grants taken while a fetch waits;
//               limit_hit forces the next slot to the fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_starve_cnt #(
   parameter int MAX_LD_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam int C_CNT_W = (MAX_LD_BURST < 1) ? 1 : $clog2(MAX_LD_BURST + 1);
   localparam logic [C_CNT_W-1:0] C_MAX = C_CNT_W'(MAX_LD_BURST);
   localparam logic [C_CNT_W-1:0] C_ONE = C_CNT_W'(1);

   logic [C_CNT_W-1:0] r_cnt;

   // Saturating count; a fetch grant or an idle fetch port restarts it
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + C_ONE;
      end
   end

   assign limit_hit = (r_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Single-port instruction memory arbiter between the IF stage
//               and a loader/debug port. Loader has priority, bounded by a
//               starvation counter. Loader port exists only when the macro
//               IMEM_ARB_LOADER_EN is defined; otherwise fetch owns memory.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int ADDR_W       = IMEM_ADDR_W,
   parameter int MAX_LD_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [31:0]       if_pc_i,
   output logic              if_gnt_o,
   output logic              if_stall_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   input  logic              ld_req_i,
   input  logic              ld_we_i,
   input  logic [31:0]       ld_addr_i,
   input  logic [31:0]       ld_wdata_i,
   output logic              ld_gnt_o,
   output logic              ld_rvalid_o,
   output logic              ld_err_o,
   output logic [31:0]       ld_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   rsp_owner_e        r_rsp;
   rsp_owner_e        w_rsp_nxt;
   logic              w_if_gnt;
   logic              w_ld_gnt;
   logic              w_ld_acc;   // loader granted with a legal address
   logic              w_ld_bad;   // loader granted with an illegal address
   logic [ADDR_W-1:0] w_if_word;
   logic [ADDR_W-1:0] w_ld_word;

   // Byte-offset and out-of-range fetch bits are dropped (wrap-around)
   assign w_if_word = if_pc_i[ADDR_W+1:2];
   assign w_ld_word = ld_addr_i[ADDR_W+1:2];

`ifdef IMEM_ARB_LOADER_EN
   logic w_limit_hit;
   logic w_addr_ok;
   logic w_cnt_inc;
   logic w_cnt_clr;
   logic w_unused_bits;

   assign w_unused_bits = ^{if_pc_i[31:ADDR_W+2], if_pc_i[1:0]};

   // Loader wins unless the fetch has waited MAX_LD_BURST loader slots
   always_comb begin
      w_addr_ok = ld_addr_ok(ld_addr_i, ADDR_W);
      w_ld_gnt  = ~rst_i & ld_req_i & ~(if_req_i & w_limit_hit);
      w_if_gnt  = ~rst_i & if_req_i & ~w_ld_gnt;
      w_ld_acc  = w_ld_gnt & w_addr_ok;
      w_ld_bad  = w_ld_gnt & ~w_addr_ok;
      w_cnt_inc = w_ld_gnt & if_req_i;
      w_cnt_clr = w_if_gnt | ~if_req_i;
   end

   imem_starve_cnt #(
      .MAX_LD_BURST (MAX_LD_BURST)
   ) u_starve_cnt (
      .clk       (clk_i),
      .rst       (rst_i),
      .inc       (w_cnt_inc),
      .clr       (w_cnt_clr),
      .limit_hit (w_limit_hit)
   );
`else
   logic w_unused_bits;

   assign w_unused_bits = ^{if_pc_i[31:ADDR_W+2], if_pc_i[1:0],
                            ld_req_i, ld_addr_i[31:ADDR_W+2], ld_addr_i[1:0]};

   // Without a loader port every fetch request owns the memory
   always_comb begin
      w_if_gnt = ~rst_i & if_req_i;
      w_ld_gnt = 1'b0;
      w_ld_acc = 1'b0;
      w_ld_bad = 1'b0;
   end
`endif

   // Drive the single memory port from whichever requester was granted
   always_comb begin
      mem_en_o    = w_if_gnt | w_ld_acc;
      mem_we_o    = w_ld_acc & ld_we_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_ld_acc) begin
         mem_addr_o = w_ld_word;
      end else if (w_if_gnt) begin
         mem_addr_o = w_if_word;
      end
      if (w_ld_acc && ld_we_i) begin
         mem_wdata_o = ld_wdata_i;
      end
      if_gnt_o   = w_if_gnt;
      ld_gnt_o   = w_ld_gnt;
      if_stall_o = if_req_i & ~w_if_gnt;
   end

   // Response-owner state register; reset drops any in-flight response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rsp <= RSP_NONE;
      end else begin
         r_rsp <= w_rsp_nxt;
      end
   end

   // Next owner follows this cycle's grant; writes and idle give no response
   always_comb begin
      w_rsp_nxt = RSP_NONE;
      if (w_if_gnt) begin
         w_rsp_nxt = RSP_IF;
      end else if (w_ld_bad) begin
         w_rsp_nxt = RSP_ERR;
      end else if (w_ld_acc && !ld_we_i) begin
         w_rsp_nxt = RSP_LD_RD;
      end
   end

   // Route the memory read data to its owner; everything quiet during reset
   always_comb begin
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      ld_rvalid_o = 1'b0;
      ld_rdata_o  = '0;
      ld_err_o    = 1'b0;
      if (!rst_i) begin
         case (r_rsp)
            RSP_IF: begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = mem_rdata_i;
            end
`ifdef IMEM_ARB_LOADER_EN
            RSP_LD_RD: begin
               ld_rvalid_o = 1'b1;
               ld_rdata_o  = mem_rdata_i;
            end
            RSP_ERR: begin
               ld_err_o = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Directed self-checking bench for imem_arbiter. Loader checks
//               are built when IMEM_ARB_LOADER_EN is defined; otherwise the
//               fetch-only behaviour with loader inputs ignored is checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_gnt, if_stall, if_rvalid;
   logic [31:0] if_rdata;
   logic        ld_req, ld_we;
   logic [31:0] ld_addr, ld_wdata;
   logic        ld_gnt, ld_rvalid, ld_err;
   logic [31:0] ld_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_W(10), .MAX_LD_BURST(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .if_req_i    (if_req),
      .if_pc_i     (if_pc),
      .if_gnt_o    (if_gnt),
      .if_stall_o  (if_stall),
      .if_rvalid_o (if_rvalid),
      .if_rdata_o  (if_rdata),
      .ld_req_i    (ld_req),
      .ld_we_i     (ld_we),
      .ld_addr_i   (ld_addr),
      .ld_wdata_i  (ld_wdata),
      .ld_gnt_o    (ld_gnt),
      .ld_rvalid_o (ld_rvalid),
      .ld_err_o    (ld_err),
      .ld_rdata_o  (ld_rdata),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs sampled 1ns later
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_pc = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; mem_rdata = '0;
      step(); step();

      // Reset beats a simultaneous fetch request
      if_req = 1'b1; if_pc = 32'h8;
      #1;
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);

      // Fetch 0x8 -> word 2, response next cycle
      step(); rst = 1'b0;
      #1;
      chk("f8_gnt", {31'd0, if_gnt}, 32'd1);
      chk("f8_mem_en", {31'd0, mem_en}, 32'd1);
      chk("f8_mem_addr", {22'd0, mem_addr}, 32'd2);
      chk("f8_stall", {31'd0, if_stall}, 32'd0);
      step(); if_req = 1'b0; mem_rdata = 32'h1234_5678;
      #1;
      chk("f8_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("f8_rdata", if_rdata, 32'h1234_5678);
      chk("f8_idle_en", {31'd0, mem_en}, 32'd0);
      step();
      #1;
      chk("idle_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("idle_rdata", if_rdata, 32'd0);

      // Upper bits wrap, byte offset ignored
      if_req = 1'b1; if_pc = 32'h0000_1007;
      #1;
      chk("wrap_addr", {22'd0, mem_addr}, 32'd1);
      step(); if_pc = 32'h0000_000B;
      #1;
      chk("offs_addr", {22'd0, mem_addr}, 32'd2);

      // Reset in the response cycle hides the response
      step(); if_pc = 32'h0000_000C;
      #1;
      chk("rs_gnt_addr", {22'd0, mem_addr}, 32'd3);
      step(); rst = 1'b1; if_req = 1'b0; mem_rdata = 32'hAAAA_5555;
      #1;
      chk("rs_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rs_rdata", if_rdata, 32'd0);
      step(); rst = 1'b0;
      #1;
      chk("rs_after_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rs_after_en", {31'd0, mem_en}, 32'd0);

`ifdef IMEM_ARB_LOADER_EN
      // Loader write beats a pending fetch; no response follows
      step(); if_req = 1'b1; if_pc = 32'h8;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
      #1;
      chk("wr_ld_gnt", {31'd0, ld_gnt}, 32'd1);
      chk("wr_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr_mem_addr", {22'd0, mem_addr}, 32'd4);
      chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_stall", {31'd0, if_stall}, 32'd1);
      step(); ld_req = 1'b0; ld_we = 1'b0;
      #1;
      chk("wr_no_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
      chk("wr_no_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("wr_fetch_gnt", {31'd0, if_gnt}, 32'd1);

      // Continuous loader reads with fetch held: L,L,L,L,F,L
      step(); if_req = 1'b0;
      step(); if_req = 1'b1; if_pc = 32'h40; ld_req = 1'b1; ld_addr = 32'h20;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         mem_rdata = 32'hC0DE_0000 + 32'(i);
         #1;
         chk($sformatf("burst_if_gnt_%0d", i), {31'd0, if_gnt}, (i == 4) ? 32'd1 : 32'd0);
         chk($sformatf("burst_ld_gnt_%0d", i), {31'd0, ld_gnt}, (i == 4) ? 32'd0 : 32'd1);
         if (i > 0) begin
            chk($sformatf("burst_ld_rv_%0d", i), {31'd0, ld_rvalid}, (i == 5) ? 32'd0 : 32'd1);
            chk($sformatf("burst_if_rv_%0d", i), {31'd0, if_rvalid}, (i == 5) ? 32'd1 : 32'd0);
         end
      end
      chk("burst_if_rdata", if_rdata, 32'hC0DE_0005);

      // Misaligned then out-of-range loader addresses
      step(); if_req = 1'b0; ld_addr = 32'h2;
      #1;
      chk("err1_gnt", {31'd0, ld_gnt}, 32'd1);
      chk("err1_mem_en", {31'd0, mem_en}, 32'd0);
      step(); ld_addr = 32'h1000; mem_rdata = 32'h5A5A_5A5A;
      #1;
      chk("err1_ld_err", {31'd0, ld_err}, 32'd1);
      chk("err1_rvalid", {31'd0, ld_rvalid}, 32'd0);
      chk("err2_mem_en", {31'd0, mem_en}, 32'd0);
      step(); ld_req = 1'b0;
      #1;
      chk("err2_ld_err", {31'd0, ld_err}, 32'd1);
      chk("err2_rvalid", {31'd0, ld_rvalid}, 32'd0);
      chk("err2_rdata", ld_rdata, 32'd0);
      step();
      #1;
      chk("err_clear", {31'd0, ld_err}, 32'd0);
`else
      // Loader requests are ignored; fetch always granted
      step(); if_req = 1'b1; if_pc = 32'h20;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
      #1;
      chk("nl_if_gnt", {31'd0, if_gnt}, 32'd1);
      chk("nl_ld_gnt", {31'd0, ld_gnt}, 32'd0);
      chk("nl_stall", {31'd0, if_stall}, 32'd0);
      chk("nl_mem_addr", {22'd0, mem_addr}, 32'd8);
      chk("nl_mem_we", {31'd0, mem_we}, 32'd0);
      chk("nl_wdata", mem_wdata, 32'd0);
      step(); ld_we = 1'b0; mem_rdata = 32'h0BAD_F00D;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         #1;
         chk($sformatf("nl_rep_gnt_%0d", i), {31'd0, if_gnt}, 32'd1);
         chk($sformatf("nl_rep_rv_%0d", i), {31'd0, if_rvalid}, 32'd1);
      end
      chk("nl_if_rdata", if_rdata, 32'h0BAD_F00D);
      chk("nl_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
      chk("nl_ld_err", {31'd0, ld_err}, 32'd0);
      chk("nl_ld_rdata", ld_rdata, 32'd0);
`endif

      step(); if_req = 1'b0; ld_req = 1'b0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared instruction memory (1024 words).
REQ-002 Parameter MAX_LD_BURST, default 4, max consecutive loader grants while a fetch is pending.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 if_req_i  input  1  fetch read request from IF stage.
REQ-006 if_pc_i  input  32  fetch byte address.
REQ-007 if_gnt_o / if_stall_o  output  1 each  fetch granted this cycle / fetch requested but not granted.
REQ-008 if_rvalid_o, if_rdata_o  output  1, 32  fetch read response.
REQ-009 ld_req_i, ld_we_i  input  1 each  loader/debug request; write when ld_we_i=1.
REQ-010 ld_addr_i, ld_wdata_i  input  32 each  loader byte address, write data.
REQ-011 ld_gnt_o, ld_rvalid_o, ld_err_o  output  1 each  loader grant, read response valid, address error.
REQ-012 ld_rdata_o  output  32  loader read data.
REQ-013 mem_en_o, mem_we_o  output  1 each; mem_addr_o  output  ADDR_W; mem_wdata_o  output  32; mem_rdata_i  input  32; memory is single-port, synchronous read, 1-cycle latency.

Function
REQ-014 At most one memory access per cycle; grant outputs are combinational from current requests and state.
REQ-015 Default priority: loader over fetch.
REQ-016 Starvation counter increments on each loader grant while if_req_i=1, clears on any fetch grant or when if_req_i=0; at count==MAX_LD_BURST, fetch is granted, loader stalled.
REQ-017 mem_addr_o = byte address [ADDR_W+1:2] of granted port; fetch address bits [1:0] ignored, upper bits truncated (wrap-around modulo 2^ADDR_W words).
REQ-018 Loader address with bits[1:0]!=0 or word index >= 2^ADDR_W: ld_gnt_o=1, mem_en_o=0, ld_err_o=1 exactly one cycle later, no ld_rvalid_o; costs the loader slot (priority/counter rules unchanged).
REQ-019 Response-owner FSM, states RSP_NONE, RSP_IF, RSP_LD_RD, RSP_ERR, updated every cycle from the current grant; a loader write or idle cycle goes to RSP_NONE.
REQ-020 RSP_IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i; RSP_LD_RD: ld_rvalid_o=1, ld_rdata_o=mem_rdata_i; otherwise rvalid outputs 0 and rdata outputs 0.
REQ-021 Read latency: grant in cycle N, rvalid/rdata in N+1; back-to-back grants give one response per cycle.
REQ-022 if_stall_o = if_req_i & ~if_gnt_o.
REQ-023 Requests not granted are not latched; requester holds request until granted.

Reset
REQ-024 While rst_i=1 at a clock edge: FSM to RSP_NONE, starvation counter to 0; in-flight response discarded.
REQ-025 During and after reset all outputs 0 until a new grant; reset has priority over simultaneous requests.

Configuration
REQ-026 Macro IMEM_ARB_LOADER_EN: defined = loader port and arbitration as above.
REQ-027 Not defined: ld_gnt_o, ld_rvalid_o, ld_err_o, ld_rdata_o tied 0, loader inputs ignored, every if_req_i granted, if_stall_o=0, no starvation counter.

Structure
REQ-028 Package imem_pkg holds IMEM_ADDR_W default, rsp_owner_e enum, and the address-range check constant.
REQ-029 Sub-module imem_starve_cnt holds the starvation counter (inputs: inc, clr; output: limit_hit).

Verification
REQ-030 Fetch only, if_pc_i=0x8 -> mem_addr_o=2 same cycle, if_rvalid_o=1 next cycle with mem_rdata_i value.
REQ-031 Loader write addr 0x10 data 0xDEADBEEF with fetch pending -> ld_gnt_o=1, mem_we_o=1, mem_addr_o=4, if_stall_o=1, no rvalid next cycle.
REQ-032 Loader reads continuous + fetch held, MAX_LD_BURST=4 -> grants L,L,L,L,F,L...; if_gnt_o in cycle 5.
REQ-033 Loader addr 0x2 and 0x1000 -> mem_en_o=0, ld_err_o=1 next cycle, ld_rvalid_o=0.
REQ-034 rst_i=1 the cycle after a fetch grant -> if_rvalid_o=0, counter 0, all outputs 0.
REQ-035 Build without IMEM_ARB_LOADER_EN, ld_req_i=1 with fetch -> fetch granted, ld_gnt_o=0.
